// File: rtl/core_muldiv.sv
// RV32M/RV64M multiply/divide unit: fixed-latency multiply, radix-2 restoring divide,
// with a single-cycle path for divide-by-zero and signed overflow.
module core_muldiv #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            FLUSH,
  input  logic            I_VALID,
  output logic            I_READY,
  input  logic            I_MUL,
  input  logic            I_MULH,
  input  logic            I_MULHSU,
  input  logic            I_MULHU,
  input  logic            I_DIV,
  input  logic            I_DIVU,
  input  logic            I_REM,
  input  logic            I_REMU,
  input  logic [XLEN-1:0] RS1,
  input  logic [XLEN-1:0] RS2,
  output logic            O_VALID,
  input  logic            O_READY,
  output logic [XLEN-1:0] RESULT
);
  // state | meaning
  // IDLE  | ready for a request
  // MUL   | waiting out the multiply latency
  // DIV   | restoring divide, one quotient bit per cycle
  // DONE  | RESULT valid, waiting for O_READY
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  typedef enum logic [3:0] {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                            OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_NONE} op_t;

  localparam int              CW       = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   MUL_CNT0 = CW'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
  localparam logic [CW-1:0]   DIV_CNT0 = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_nxt;
  op_t               op_in, op_q, op_cur;
  logic              accept, res_load;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   a_q, b_q, a_cur, b_cur;
  logic [XLEN-1:0]   rem_q, quo_q, dvs_q, rem_nx, quo_nx, diff;
  logic [XLEN:0]     shifted;
  logic              fits, neg_quo_q, neg_rem_q, is_rem_q;
  logic              in_mul, in_div, in_signed, in_rem, in_zero, in_ovf, in_neg_a, in_neg_b;
  logic [XLEN-1:0]   mag_a, mag_b, fast_res, mul_res, div_res, res_val;
  logic              a_sgn, b_sgn;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;

  always_comb begin
    op_in = OP_NONE;
    if      (I_MUL)    op_in = OP_MUL;
    else if (I_MULH)   op_in = OP_MULH;
    else if (I_MULHSU) op_in = OP_MULHSU;
    else if (I_MULHU)  op_in = OP_MULHU;
    else if (I_DIV)    op_in = OP_DIV;
    else if (I_DIVU)   op_in = OP_DIVU;
    else if (I_REM)    op_in = OP_REM;
    else if (I_REMU)   op_in = OP_REMU;
  end

  always_comb begin
    in_mul    = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    in_div    = op_in inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    in_signed = op_in inside {OP_DIV, OP_REM};
    in_rem    = op_in inside {OP_REM, OP_REMU};
    in_zero   = (RS2 == '0);
    in_ovf    = in_signed && (RS1 == MIN_NEG) && (RS2 == '1);
    in_neg_a  = in_signed & RS1[XLEN-1];
    in_neg_b  = in_signed & RS2[XLEN-1];
    mag_a     = in_neg_a ? -RS1 : RS1;
    mag_b     = in_neg_b ? -RS2 : RS2;
    if (in_zero) fast_res = in_rem ? RS1 : '1;
    else         fast_res = in_rem ? '0 : RS1;
  end

  assign accept = I_VALID & I_READY & ~FLUSH;

  // Single-cycle multiply latency has to take its operands straight from the ports.
  assign a_cur  = (state == S_IDLE) ? RS1 : a_q;
  assign b_cur  = (state == S_IDLE) ? RS2 : b_q;
  assign op_cur = (state == S_IDLE) ? op_in : op_q;

  assign a_sgn   = a_cur[XLEN-1] & ((op_cur == OP_MULH) || (op_cur == OP_MULHSU));
  assign b_sgn   = b_cur[XLEN-1] & (op_cur == OP_MULH);
  assign a_ext   = {{XLEN{a_sgn}}, a_cur};
  assign b_ext   = {{XLEN{b_sgn}}, b_cur};
  assign prod    = a_ext * b_ext;
  assign mul_res = (op_cur == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // Partial remainder stays below the divisor, so the XLEN-bit difference is exact.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign fits    = (shifted >= {1'b0, dvs_q});
  assign diff    = shifted[XLEN-1:0] - dvs_q;
  assign rem_nx  = fits ? diff : shifted[XLEN-1:0];
  assign quo_nx  = {quo_q[XLEN-2:0], fits};
  assign div_res = is_rem_q ? (neg_rem_q ? -rem_nx : rem_nx)
                            : (neg_quo_q ? -quo_nx : quo_nx);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      I_READY <= 1'b1;
      O_VALID <= 1'b0;
    end else begin
      state   <= state_nxt;
      I_READY <= (state_nxt == S_IDLE);
      O_VALID <= (state_nxt == S_DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    res_load  = 1'b0;
    res_val   = '0;
    case (state)
      S_IDLE: if (accept) begin
        if (in_mul) begin
          if (MUL_LAT == 1) begin
            state_nxt = S_DONE;
            res_load  = 1'b1;
            res_val   = mul_res;
          end else begin
            state_nxt = S_MUL;
          end
        end else if (in_div) begin
          if (in_zero || in_ovf) begin
            state_nxt = S_DONE;
            res_load  = 1'b1;
            res_val   = fast_res;
          end else begin
            state_nxt = S_DIV;
          end
        end else begin
          state_nxt = S_DONE;
          res_load  = 1'b1;
        end
      end
      S_MUL: if (cnt == '0) begin
        state_nxt = S_DONE;
        res_load  = 1'b1;
        res_val   = mul_res;
      end
      S_DIV: if (cnt == '0) begin
        state_nxt = S_DONE;
        res_load  = 1'b1;
        res_val   = div_res;
      end
      S_DONE:  if (O_READY) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (FLUSH) begin
      state_nxt = S_IDLE;
      res_load  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      RESULT    <= '0;
      op_q      <= OP_NONE;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      cnt       <= '0;
    end else begin
      if (res_load) RESULT <= res_val;
      if (accept) begin
        op_q      <= op_in;
        a_q       <= RS1;
        b_q       <= RS2;
        quo_q     <= mag_a;
        dvs_q     <= mag_b;
        rem_q     <= '0;
        neg_quo_q <= in_neg_a ^ in_neg_b;
        neg_rem_q <= in_neg_a;
        is_rem_q  <= in_rem;
        cnt       <= in_mul ? MUL_CNT0 : DIV_CNT0;
      end else if (state == S_DIV) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt   <= cnt - 1'b1;
      end else if (state == S_MUL) begin
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_core_muldiv.sv
// Bench for core_muldiv: directed vectors, handshake/flush/reset sequences and
// randomized operations against an arithmetic reference, on a 32-bit and a 64-bit instance.
module tb_core_muldiv;
  localparam logic [7:0] S_MUL = 8'h01, S_MULH = 8'h02, S_MULHSU = 8'h04, S_MULHU = 8'h08;
  localparam logic [7:0] S_DIV = 8'h10, S_DIVU = 8'h20, S_REM = 8'h40, S_REMU = 8'h80;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush;
  logic        iv32, ir32, ov32, ordy32;
  logic [7:0]  sel32;
  logic [31:0] a32, b32, res32;
  logic        iv64, ir64, ov64, ordy64;
  logic [7:0]  sel64;
  logic [63:0] a64, b64, res64;

  int n_tests = 0;
  int n_fail  = 0;

  core_muldiv #(.XLEN(32), .MUL_LAT(2)) dut32 (
    .CLK(clk), .RST_N(rst_n), .FLUSH(flush), .I_VALID(iv32), .I_READY(ir32),
    .I_MUL(sel32[0]), .I_MULH(sel32[1]), .I_MULHSU(sel32[2]), .I_MULHU(sel32[3]),
    .I_DIV(sel32[4]), .I_DIVU(sel32[5]), .I_REM(sel32[6]), .I_REMU(sel32[7]),
    .RS1(a32), .RS2(b32), .O_VALID(ov32), .O_READY(ordy32), .RESULT(res32));

  core_muldiv #(.XLEN(64), .MUL_LAT(1)) dut64 (
    .CLK(clk), .RST_N(rst_n), .FLUSH(flush), .I_VALID(iv64), .I_READY(ir64),
    .I_MUL(sel64[0]), .I_MULH(sel64[1]), .I_MULHSU(sel64[2]), .I_MULHU(sel64[3]),
    .I_DIV(sel64[4]), .I_DIVU(sel64[5]), .I_REM(sel64[6]), .I_REMU(sel64[7]),
    .RS1(a64), .RS2(b64), .O_VALID(ov64), .O_READY(ordy64), .RESULT(res64));

  typedef struct {
    logic [7:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int prio(input logic [7:0] sel);
    int op = 8;
    for (int i = 7; i >= 0; i--) if (sel[i]) op = i;
    return op;
  endfunction

  function automatic logic [63:0] xmask(input int xl);
    return (xl == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic bit is_ovf(input int xl, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mn = (xl == 32) ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
    return ((a & xmask(xl)) == mn) && ((b & xmask(xl)) == xmask(xl));
  endfunction

  // Full-width arithmetic in 128 bits; SV division truncates toward zero and % follows the dividend.
  function automatic logic [63:0] ref_op(input int xl, input logic [7:0] sel,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [127:0]        ua, ub, r;
    logic signed [127:0] sa, sb;
    ua = {64'b0, a & xmask(xl)};
    ub = {64'b0, b & xmask(xl)};
    sa = (xl == 32) ? {{96{a[31]}}, a[31:0]} : {{64{a[63]}}, a};
    sb = (xl == 32) ? {{96{b[31]}}, b[31:0]} : {{64{b[63]}}, b};
    r  = '0;
    case (prio(sel))
      0: r = ua * ub;
      1: r = (sa * sb) >> xl;
      2: r = (sa * ub) >> xl;
      3: r = (ua * ub) >> xl;
      4: if (ub == 0) r = '1; else if (is_ovf(xl, a, b)) r = ua; else r = sa / sb;
      5: if (ub == 0) r = '1; else r = ua / ub;
      6: if (ub == 0) r = ua; else if (is_ovf(xl, a, b)) r = '0; else r = sa % sb;
      7: if (ub == 0) r = ua; else r = ua % ub;
      default: r = '0;
    endcase
    return r[63:0] & xmask(xl);
  endfunction

  function automatic int exp_lat(input int xl, input int ml, input logic [7:0] sel,
                                 input logic [63:0] a, input logic [63:0] b);
    int op = prio(sel);
    if (op < 4) return ml;
    if (op == 8) return 1;
    if ((b & xmask(xl)) == 0) return 1;
    if ((op == 4 || op == 6) && is_ovf(xl, a, b)) return 1;
    return xl + 1;
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [63:0] pick64();
    case ($urandom_range(0, 6))
      0: return 64'h0;
      1: return 64'h1;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic [7:0] pick_sel();
    int k = $urandom_range(0, 9);
    if (k < 7)  return 8'(1 << $urandom_range(0, 7));
    if (k == 7) return 8'h00;
    return 8'($urandom);
  endfunction

  task automatic run_op(input bit w64, input logic [7:0] sel, input logic [63:0] a,
                        input logic [63:0] b, output logic [63:0] res, output int lat);
    check("ready_before", w64 ? ir64 : ir32, 1);
    if (w64) begin sel64 = sel; a64 = a; b64 = b; iv64 = 1'b1; end
    else     begin sel32 = sel; a32 = a[31:0]; b32 = b[31:0]; iv32 = 1'b1; end
    @(posedge clk); #1;
    iv32 = 1'b0; iv64 = 1'b0;
    sel32 = 8'($urandom); sel64 = 8'($urandom);
    a32 = $urandom; b32 = $urandom; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
    check("ready_low", w64 ? ir64 : ir32, 0);
    lat = 1;
    while (!(w64 ? ov64 : ov32) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = w64 ? res64 : {32'b0, res32};
    @(posedge clk); #1;
    check("handshake_ovalid", w64 ? ov64 : ov32, 0);
    check("handshake_iready", w64 ? ir64 : ir32, 1);
  endtask

  task automatic issue32(input logic [7:0] sel, input logic [31:0] a, input logic [31:0] b);
    sel32 = sel; a32 = a; b32 = b; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0; sel32 = 8'h00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[16];
    logic [63:0] r;
    int          lat;
    bit          seen;
    logic [7:0]  s;
    logic [63:0] ra, rb;

    vecs[0]  = '{S_MUL,          32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2};
    vecs[1]  = '{S_MULHU,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
    vecs[2]  = '{S_MULH,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2};
    vecs[3]  = '{S_MULHSU,       32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2};
    vecs[4]  = '{S_DIV,          32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
    vecs[5]  = '{S_REM,          32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{S_DIVU,         32'd100,       32'd7,         32'd14,        33};
    vecs[7]  = '{S_REMU,         32'd100,       32'd7,         32'd2,         33};
    vecs[8]  = '{S_DIVU,         32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{S_REM,          32'd5,         32'd0,         32'd5,         1};
    vecs[10] = '{S_DIV,          32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{S_REM,          32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[12] = '{8'h00,          32'd5,         32'd6,         32'h0000_0000, 1};
    vecs[13] = '{S_DIVU | S_REMU, 32'd100,      32'd7,         32'd14,        33};
    vecs[14] = '{S_DIVU,         32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};
    vecs[15] = '{S_REMU,         32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, 1};

    rst_n = 1'b0; flush = 1'b0;
    iv32 = 1'b0; sel32 = 8'h00; a32 = '0; b32 = '0; ordy32 = 1'b1;
    iv64 = 1'b0; sel64 = 8'h00; a64 = '0; b64 = '0; ordy64 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_iready32", ir32, 1);
    check("reset_ovalid32", ov32, 0);
    check("reset_result32", res32, 0);
    check("reset_iready64", ir64, 1);
    check("reset_ovalid64", ov64, 0);
    check("reset_result64", res64, 0);

    for (int i = 0; i < 16; i++) begin
      run_op(1'b0, vecs[i].sel, {32'b0, vecs[i].a}, {32'b0, vecs[i].b}, r, lat);
      check($sformatf("vec%0d_result", i), r, {32'b0, vecs[i].exp});
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    // Backpressure: result held for 5 cycles, then released by a one-cycle O_READY.
    ordy32 = 1'b0;
    issue32(S_MUL, 32'd6, 32'd7);
    lat = 1;
    while (!ov32 && lat < 200) begin @(posedge clk); #1; lat++; end
    check("bp_latency", lat, 2);
    check("bp_result", res32, 42);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold_ovalid%0d", k), ov32, 1);
      check($sformatf("bp_hold_result%0d", k), res32, 42);
      check($sformatf("bp_hold_iready%0d", k), ir32, 0);
    end
    ordy32 = 1'b1;
    @(posedge clk); #1;
    ordy32 = 1'b0;
    check("bp_release_ovalid", ov32, 0);
    check("bp_release_iready", ir32, 1);
    check("bp_release_result", res32, 42);
    ordy32 = 1'b1;

    // FLUSH in the same cycle as a request drops the request.
    sel32 = S_MUL; a32 = 32'd9; b32 = 32'd9; iv32 = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0; flush = 1'b0; sel32 = 8'h00;
    check("flush_drop_iready", ir32, 1);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin @(posedge clk); #1; seen |= ov32; end
    check("flush_drop_no_ovalid", seen, 0);

    // FLUSH at cycle 10 of a divide.
    issue32(S_DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_div_iready", ir32, 1);
    check("flush_div_ovalid", ov32, 0);
    check("flush_div_result_kept", res32, 42);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1; seen |= ov32; end
    check("flush_div_no_ovalid", seen, 0);
    run_op(1'b0, S_MUL, 64'd3, 64'd4, r, lat);
    check("post_flush_mul_result", r, 12);
    check("post_flush_mul_latency", lat, 2);

    // Same scenario with a synchronous reset in place of FLUSH.
    issue32(S_DIV, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_div_iready", ir32, 1);
    check("rst_div_ovalid", ov32, 0);
    check("rst_div_result", res32, 0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1; seen |= ov32; end
    check("rst_div_no_ovalid", seen, 0);
    run_op(1'b0, S_MUL, 64'd3, 64'd4, r, lat);
    check("post_rst_mul_result", r, 12);
    check("post_rst_mul_latency", lat, 2);

    // 64-bit instance, single-cycle multiply.
    run_op(1'b1, S_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, r, lat);
    check("x64_mulhu_result", r, 64'd1);
    check("x64_mulhu_latency", lat, 1);
    run_op(1'b1, S_DIVU, 64'h8000_0000_0000_0000, 64'd3, r, lat);
    check("x64_divu_result", r, 64'h2AAA_AAAA_AAAA_AAAA);
    check("x64_divu_latency", lat, 65);

    for (int i = 0; i < 40; i++) begin
      s = pick_sel(); ra = {32'b0, pick32()}; rb = {32'b0, pick32()};
      run_op(1'b0, s, ra, rb, r, lat);
      check($sformatf("rnd32_%0d_result sel=%h a=%h b=%h", i, s, ra, rb), r, ref_op(32, s, ra, rb));
      check($sformatf("rnd32_%0d_latency", i), lat, exp_lat(32, 2, s, ra, rb));
    end

    for (int i = 0; i < 15; i++) begin
      s = pick_sel(); ra = pick64(); rb = pick64();
      run_op(1'b1, s, ra, rb, r, lat);
      check($sformatf("rnd64_%0d_result sel=%h a=%h b=%h", i, s, ra, rb), r, ref_op(64, s, ra, rb));
      check($sformatf("rnd64_%0d_latency", i), lat, exp_lat(64, 1, s, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/core_muldiv.md
# core_muldiv

Parametrised multi-cycle multiply/divide unit implementing the RV32M/RV64M operations alongside the single-cycle integer ALU in the execute stage. Operands arrive with a one-hot operation select under a valid/ready handshake. Results leave under a valid/ready handshake. Multiplies complete in a fixed pipelined latency. Divides and remainders use an iterative radix-2 restoring divider, with a fast path for the architectural corner cases.

## Interface
- XLEN, 32: operand/result width; 32 or 64.
- MUL_LAT, 2: multiply latency in cycles from accept to O_VALID; range 1–4.
- CLK  in  1  clock.
- RST_N  in  1  synchronous, active-low reset.
- FLUSH  in  1  abort any operation in flight; pipeline squash.
- I_VALID  in  1  operation request.
- I_READY  out  1  unit can accept; high only in IDLE.
- I_MUL, I_MULH, I_MULHSU, I_MULHU, I_DIV, I_DIVU, I_REM, I_REMU  in  1 each  one-hot operation select.
- RS1, RS2  in  XLEN  operands; RS1 is the dividend/multiplicand.
- O_VALID  out  1  RESULT valid.
- O_READY  in  1  consumer takes the result.
- RESULT  out  XLEN  registered result.

## Operation
- Accept occurs when I_VALID & I_READY at a rising edge. The op select and operands are captured in that cycle; later input changes are ignored.
- Op priority, if more than one select bit is set: MUL > MULH > MULHSU > MULHU > DIV > DIVU > REM > REMU.
- If no select bit is set, the request is accepted anyway and produces RESULT=0.
- States and transitions:
  - IDLE: on accept, go to MUL, DIV or DONE.
  - MUL: counts MUL_LAT cycles, then goes to DONE.
  - DIV: performs XLEN iterations, then goes to DONE.
  - DONE: holds O_VALID; goes to IDLE when O_READY is high.
- Multiply: full 2·XLEN-bit product.
  - MUL returns the low XLEN bits.
  - MULH returns the high XLEN bits, signed×signed.
  - MULHSU returns the high XLEN bits, signed RS1 × unsigned RS2.
  - MULHU returns the high XLEN bits, unsigned×unsigned.
- Divide, signed ops: divide the operand magnitudes. Negate the quotient if the operand signs differ. Negate the remainder if RS1 is negative. The remainder sign follows the dividend.
- Divide corner cases take the fast path (accept → DONE directly, no iterations):
  - RS2=0: DIV/DIVU return all ones; REM/REMU return RS1.
  - Signed overflow (RS1 = most negative value, RS2 = −1): DIV returns RS1; REM returns 0.
- FLUSH: the next state is IDLE from any state and O_VALID is cleared. Any in-flight result is discarded.
  - FLUSH takes priority over accept in the same cycle; I_READY is still high in IDLE, but the request is dropped.
- Reset, mid-operation included, behaves exactly like FLUSH and also clears RESULT.

## Timing
- Reset values: I_READY=1, O_VALID=0, RESULT=0, state=IDLE.
- Let the accept edge be cycle 0. O_VALID first goes high at:
  - multiply: cycle MUL_LAT;
  - normal divide: cycle XLEN+1;
  - fast-path divide or no-op request: cycle 1.
- I_READY is low from cycle 1 until the cycle after the O_VALID & O_READY handshake. The unit accepts no back-to-back request in the handshake cycle.
- RESULT is stable while O_VALID is high and not yet consumed. Once consumed, RESULT holds its last value; it is not cleared.
- With O_READY held high, throughput is one operation per latency+1 cycles.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset then MUL, XLEN=32: RS1=0xFFFFFFFF, RS2=0xFFFFFFFF, O_READY=1.
  - Expect RESULT=0x00000001 with O_VALID at cycle MUL_LAT.
  - Repeat with MULHU: expect 0xFFFFFFFE. Repeat with MULH: expect 0x00000000. Repeat with MULHSU: expect 0xFFFFFFFF.
- DIV with RS1=−7, RS2=2: expect −3 (0xFFFFFFFD) at cycle 33. REM with the same operands: expect −1 (0xFFFFFFFF). DIVU with RS1=100, RS2=7: expect 14. REMU with the same operands: expect 2.
- Corner cases, each with O_VALID at cycle 1:
  - DIVU with RS2=0: expect 0xFFFFFFFF.
  - REM with RS1=5, RS2=0: expect 5.
  - DIV with RS1=0x80000000, RS2=0xFFFFFFFF: expect 0x80000000.
  - REM with the same operands: expect 0.
- Backpressure: O_READY=0 for 5 cycles after O_VALID.
  - RESULT and O_VALID must stay stable and I_READY must stay low.
  - O_READY=1 for one cycle: O_VALID falls and I_READY rises on the next cycle.
- FLUSH asserted at cycle 10 of a DIV: O_VALID never rises and I_READY=1 on the next cycle. A subsequent MUL 3×4 returns 12. Repeat the scenario with RST_N=0 in place of FLUSH; expect the same behaviour plus RESULT=0.
- Instantiate with XLEN=64, MUL_LAT=1: MULHU of 0xFFFFFFFFFFFFFFFF × 2 returns 1 at cycle 1. DIVU of 2^63 by 3 returns 0x2AAAAAAAAAAAAAAA at cycle 65.
